// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 8-bit pipeline.
//
// Takes the ID/EX register outputs and does four things:
//   - selects forwarded operands
//   - runs the ALU
//   - holds the condition-code register (ccr = {V,C,N,Z})
//   - resolves branches
// The result and pass-through control bits are registered into the EX/MEM
// register that feeds the memory stage.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stall               holds the EX/MEM register and the CCR
//   BType .. IO_Write   decoded control from ID/EX
//   ALU_op              ALU function select
//   ra_val, rb_val      register operands from ID/EX
//   imm, pc_plus1       immediate and return address from ID/EX
//   ra, rb              register indices from ID/EX
//   fwd_a_sel/_b_sel    forwarding selects:
//                         00/11 ID/EX value, 01 exmem_alu_result, 10 wb_data
//   wb_data             write-back value used for forwarding
//   ccr_save/_restore   interrupt entry / RTI CCR shadow control
//   branch_taken/target combinational branch resolution
//   ccr                 registered condition codes {V,C,N,Z}
//   exmem_*             EX/MEM pipeline register
//
// Build option
//   EX_CCR_SHADOW_EN  adds a 4-bit CCR shadow register driven by
//                     ccr_save/ccr_restore. When it is undefined, both of
//                     those inputs are ignored.
// ---------------------------------------------------------------------------
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [1:0] BType,
    input  logic [1:0] MemToReg,
    input  logic [1:0] RegDistidx,
    input  logic       RegWrite,
    input  logic       MemWrite,
    input  logic       MemRead,
    input  logic       UpdateFlags,
    input  logic       ALU_src,
    input  logic       IO_Write,
    input  logic [3:0] ALU_op,
    input  logic [7:0] ra_val,
    input  logic [7:0] rb_val,
    input  logic [7:0] imm,
    input  logic [7:0] pc_plus1,
    input  logic [1:0] ra,
    input  logic [1:0] rb,
    input  logic [1:0] fwd_a_sel,
    input  logic [1:0] fwd_b_sel,
    input  logic [7:0] wb_data,
    input  logic       ccr_save,
    input  logic       ccr_restore,
    output logic       branch_taken,
    output logic [7:0] branch_target,
    output logic [3:0] ccr,
    output logic [7:0] exmem_alu_result,
    output logic [7:0] exmem_store_data,
    output logic [7:0] exmem_pc_plus1,
    output logic [1:0] exmem_dest,
    output logic [1:0] exmem_MemToReg,
    output logic       exmem_RegWrite,
    output logic       exmem_MemWrite,
    output logic       exmem_MemRead,
    output logic       exmem_IO_Write
);

    localparam logic [3:0] OP_PASSB = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_NEG   = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;
    localparam logic [3:0] OP_RLC   = 4'd9;
    localparam logic [3:0] OP_RRC   = 4'd10;
    localparam logic [3:0] OP_SETC  = 4'd11;
    localparam logic [3:0] OP_CLRC  = 4'd12;
    localparam logic [3:0] OP_PASSA = 4'd13;

    logic [7:0] op_a;
    logic [7:0] fwd_b;
    logic [7:0] op_b;
    logic [7:0] alu_res;
    logic [8:0] sum9;
    logic       c_next;
    logic       v_next;
    logic       zn_upd;
    logic [3:0] flags_next;
    logic [1:0] dest;

    wire ccr_z = ccr[0];
    wire ccr_c = ccr[2];
    wire ccr_v = ccr[3];

    // Operand forwarding. 11 falls back to the ID/EX value.
    always_comb begin
        case (fwd_a_sel)
            2'b01:   op_a = exmem_alu_result;
            2'b10:   op_a = wb_data;
            default: op_a = ra_val;
        endcase
        case (fwd_b_sel)
            2'b01:   fwd_b = exmem_alu_result;
            2'b10:   fwd_b = wb_data;
            default: fwd_b = rb_val;
        endcase
        op_b = ALU_src ? imm : fwd_b;
    end

    // ALU. sum9[8] is the carry-out for additions and the borrow for
    // subtractions, because it comes from a 9-bit zero-extended difference.
    always_comb begin
        alu_res = op_b;
        sum9    = 9'd0;
        c_next  = ccr_c;
        v_next  = ccr_v;
        zn_upd  = 1'b1;
        case (ALU_op)
            OP_ADD: begin
                sum9    = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum9[7:0];
                c_next  = sum9[8];
                v_next  = (op_a[7] == op_b[7]) && (alu_res[7] != op_a[7]);
            end
            OP_SUB: begin
                sum9    = {1'b0, op_a} - {1'b0, op_b};
                alu_res = sum9[7:0];
                c_next  = sum9[8];
                v_next  = (op_a[7] != op_b[7]) && (alu_res[7] != op_a[7]);
            end
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_NOT:   alu_res = ~op_b;
            OP_NEG: begin
                sum9    = 9'd0 - {1'b0, op_b};
                alu_res = sum9[7:0];
                c_next  = sum9[8];
                v_next  = op_b[7] && alu_res[7];
            end
            OP_INC: begin
                sum9    = {1'b0, op_b} + 9'd1;
                alu_res = sum9[7:0];
                c_next  = sum9[8];
                v_next  = !op_b[7] && alu_res[7];
            end
            OP_DEC: begin
                sum9    = {1'b0, op_b} - 9'd1;
                alu_res = sum9[7:0];
                c_next  = sum9[8];
                v_next  = op_b[7] && !alu_res[7];
            end
            OP_RLC: begin
                alu_res = {op_b[6:0], ccr_c};
                c_next  = op_b[7];
            end
            OP_RRC: begin
                alu_res = {ccr_c, op_b[7:1]};
                c_next  = op_b[0];
            end
            OP_SETC: begin
                c_next = 1'b1;
                zn_upd = 1'b0;
            end
            OP_CLRC: begin
                c_next = 1'b0;
                zn_upd = 1'b0;
            end
            OP_PASSA: alu_res = op_a;
            default:  alu_res = op_b;
        endcase
    end

    always_comb begin
        flags_next = {v_next, c_next, ccr[1], ccr[0]};
        if (zn_upd) begin
            flags_next[1] = alu_res[7];
            flags_next[0] = (alu_res == 8'd0);
        end
    end

    // Branch resolution looks only at the registered CCR, so flags produced
    // by the instruction currently in EX are seen by the next one.
    always_comb begin
        case (BType)
            2'b01:   branch_taken = ccr_z;
            2'b10:   branch_taken = ccr_c;
            2'b11:   branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
        branch_target = fwd_b;
    end

    always_comb begin
        case (RegDistidx)
            2'b00:   dest = ra;
            2'b01:   dest = rb;
            default: dest = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_alu_result <= 8'd0;
            exmem_store_data <= 8'd0;
            exmem_pc_plus1   <= 8'd0;
            exmem_dest       <= 2'd0;
            exmem_MemToReg   <= 2'd0;
            exmem_RegWrite   <= 1'b0;
            exmem_MemWrite   <= 1'b0;
            exmem_MemRead    <= 1'b0;
            exmem_IO_Write   <= 1'b0;
        end else if (!stall) begin
            exmem_alu_result <= alu_res;
            exmem_store_data <= fwd_b;
            exmem_pc_plus1   <= pc_plus1;
            exmem_dest       <= dest;
            exmem_MemToReg   <= MemToReg;
            exmem_RegWrite   <= RegWrite;
            exmem_MemWrite   <= MemWrite;
            exmem_MemRead    <= MemRead;
            exmem_IO_Write   <= IO_Write;
        end
    end

`ifdef EX_CCR_SHADOW_EN
    logic [3:0] ccr_shadow;

    // A restore beats a flag write in the same cycle. When save and restore
    // happen together, the two registers swap their old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr        <= 4'd0;
            ccr_shadow <= 4'd0;
        end else if (!stall) begin
            if (ccr_restore)
                ccr <= ccr_shadow;
            else if (UpdateFlags)
                ccr <= flags_next;
            if (ccr_save)
                ccr_shadow <= ccr;
        end
    end
`else
    logic unused_shadow_ctrl;
    assign unused_shadow_ctrl = ccr_save ^ ccr_restore;

    always_ff @(posedge clk) begin
        if (rst)
            ccr <= 4'd0;
        else if (!stall && UpdateFlags)
            ccr <= flags_next;
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios followed by random cycles, all
// checked against a behavioural model built on integer arithmetic.
module tb_ex_stage;

    logic       clk = 1'b0;
    logic       rst, stall;
    logic [1:0] BType, MemToReg, RegDistidx;
    logic       RegWrite, MemWrite, MemRead, UpdateFlags, ALU_src, IO_Write;
    logic [3:0] ALU_op;
    logic [7:0] ra_val, rb_val, imm, pc_plus1, wb_data;
    logic [1:0] ra, rb, fwd_a_sel, fwd_b_sel;
    logic       ccr_save, ccr_restore;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [3:0] ccr;
    logic [7:0] exmem_alu_result, exmem_store_data, exmem_pc_plus1;
    logic [1:0] exmem_dest, exmem_MemToReg;
    logic       exmem_RegWrite, exmem_MemWrite, exmem_MemRead, exmem_IO_Write;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .BType(BType), .MemToReg(MemToReg), .RegDistidx(RegDistidx),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .UpdateFlags(UpdateFlags), .ALU_src(ALU_src), .IO_Write(IO_Write),
        .ALU_op(ALU_op), .ra_val(ra_val), .rb_val(rb_val), .imm(imm),
        .pc_plus1(pc_plus1), .ra(ra), .rb(rb),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_data(wb_data),
        .ccr_save(ccr_save), .ccr_restore(ccr_restore),
        .branch_taken(branch_taken), .branch_target(branch_target), .ccr(ccr),
        .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
        .exmem_pc_plus1(exmem_pc_plus1), .exmem_dest(exmem_dest),
        .exmem_MemToReg(exmem_MemToReg), .exmem_RegWrite(exmem_RegWrite),
        .exmem_MemWrite(exmem_MemWrite), .exmem_MemRead(exmem_MemRead),
        .exmem_IO_Write(exmem_IO_Write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state. CCR bits are kept as separate booleans.
    int   m_res, m_store, m_pc, m_dest, m_mtr;
    bit   m_rw, m_mw, m_mr, m_io;
    bit   mz, mn, mc, mv;
    bit   sz, sn, sc, sv;

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic int model_fb();
        if (fwd_b_sel == 2'b01) return m_res;
        if (fwd_b_sel == 2'b10) return int'(wb_data);
        return int'(rb_val);
    endfunction

    function automatic int model_fa();
        if (fwd_a_sel == 2'b01) return m_res;
        if (fwd_a_sel == 2'b10) return int'(wb_data);
        return int'(ra_val);
    endfunction

    function automatic bit model_taken();
        if (BType == 2'b01) return mz;
        if (BType == 2'b10) return mc;
        if (BType == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model across one rising edge, using the inputs held
    // during the cycle.
    task automatic model_edge();
        int a, b, full, sfull, r;
        bit nz, nn, nc, nv, zn;
        a  = model_fa();
        b  = ALU_src ? int'(imm) : model_fb();
        nc = mc; nv = mv; zn = 1; r = b;
        case (int'(ALU_op))
            1:  begin full = a + b; sfull = sgn(a) + sgn(b); r = full % 256;
                      nc = full > 255; nv = sfull > 127 || sfull < -128; end
            2:  begin full = a - b; sfull = sgn(a) - sgn(b); r = (full + 256) % 256;
                      nc = a < b; nv = sfull > 127 || sfull < -128; end
            3:  r = a & b;
            4:  r = a | b;
            5:  r = 255 - b;
            6:  begin r = (256 - b) % 256; nc = b > 0; nv = -sgn(b) > 127; end
            7:  begin r = (b + 1) % 256; nc = b == 255; nv = sgn(b) + 1 > 127; end
            8:  begin r = (b + 255) % 256; nc = b < 1; nv = sgn(b) - 1 < -128; end
            9:  begin r = (b * 2) % 256 + (mc ? 1 : 0); nc = b >= 128; end
            10: begin r = b / 2 + (mc ? 128 : 0); nc = (b % 2) == 1; end
            11: begin nc = 1; zn = 0; end
            12: begin nc = 0; zn = 0; end
            13: r = a;
            default: r = b;
        endcase
        nz = zn ? (r == 0)  : mz;
        nn = zn ? (r >= 128) : mn;
        if (rst) begin
            m_res = 0; m_store = 0; m_pc = 0; m_dest = 0; m_mtr = 0;
            m_rw = 0; m_mw = 0; m_mr = 0; m_io = 0;
            mz = 0; mn = 0; mc = 0; mv = 0;
            sz = 0; sn = 0; sc = 0; sv = 0;
        end else if (!stall) begin
            bit oz, on, oc, ov;
            oz = mz; on = mn; oc = mc; ov = mv;
            m_store = model_fb();
            m_res = r; m_pc = int'(pc_plus1); m_mtr = int'(MemToReg);
            m_dest = (RegDistidx == 2'b00) ? int'(ra) : (RegDistidx == 2'b01) ? int'(rb) : 3;
            m_rw = RegWrite; m_mw = MemWrite; m_mr = MemRead; m_io = IO_Write;
`ifdef EX_CCR_SHADOW_EN
            if (ccr_restore) begin
                mz = sz; mn = sn; mc = sc; mv = sv;
            end else if (UpdateFlags) begin
                mz = nz; mn = nn; mc = nc; mv = nv;
            end
            if (ccr_save) begin
                sz = oz; sn = on; sc = oc; sv = ov;
            end
`else
            if (UpdateFlags) begin
                mz = nz; mn = nn; mc = nc; mv = nv;
            end
`endif
        end
    endtask

    // Called just after a falling edge with the inputs already set. Checks
    // the combinational outputs, steps the clock, checks the registers, and
    // returns at the next falling edge.
    task automatic cycle();
        #1;
        check("branch_taken", 32'(branch_taken), 32'(model_taken()));
        check("branch_target", 32'(branch_target), 32'(model_fb()));
        @(posedge clk);
        model_edge();
        #1;
        check("ccr", 32'(ccr), {28'd0, mv, mc, mn, mz});
        check("alu_result", 32'(exmem_alu_result), 32'(m_res));
        check("store_data", 32'(exmem_store_data), 32'(m_store));
        check("pc_plus1", 32'(exmem_pc_plus1), 32'(m_pc));
        check("dest", 32'(exmem_dest), 32'(m_dest));
        check("ctrl", {24'd0, exmem_MemToReg, exmem_RegWrite, exmem_MemWrite,
                       exmem_MemRead, exmem_IO_Write},
              {24'd0, 2'(m_mtr), m_rw, m_mw, m_mr, m_io});
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; BType = 0; MemToReg = 0; RegDistidx = 0;
        RegWrite = 0; MemWrite = 0; MemRead = 0; UpdateFlags = 0; ALU_src = 0;
        IO_Write = 0; ALU_op = 0; ra_val = 0; rb_val = 0; imm = 0; pc_plus1 = 0;
        ra = 0; rb = 0; fwd_a_sel = 0; fwd_b_sel = 0; wb_data = 0;
        ccr_save = 0; ccr_restore = 0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic uf);
        idle();
        ALU_op = op; ra_val = a; rb_val = b; UpdateFlags = uf;
    endtask

    logic [7:0] held;

    initial begin
        idle();
        m_res = 0; m_store = 0; m_pc = 0; m_dest = 0; m_mtr = 0;
        m_rw = 0; m_mw = 0; m_mr = 0; m_io = 0;
        mz = 0; mn = 0; mc = 0; mv = 0; sz = 0; sn = 0; sc = 0; sv = 0;
        @(negedge clk);

        // Reset wins over stall, and with it over the RegWrite request.
        rst = 1; stall = 1; RegWrite = 1; ccr_restore = 1; pc_plus1 = 8'h55;
        cycle();
        check("reset_ccr", 32'(ccr), 32'd0);
        check("reset_regwrite", 32'(exmem_RegWrite), 32'd0);

        // Signed overflow on ADD: expect N=1, V=1.
        alu(4'd1, 8'h7F, 8'h01, 1); cycle();
        check("ovf_result", 32'(exmem_alu_result), 32'h80);
        check("ovf_ccr", 32'(ccr), 32'b1010);

        // SUB of equal values, then a branch on Z and a branch on C.
        alu(4'd2, 8'h05, 8'h05, 1); cycle();
        check("sub_ccr", 32'(ccr), 32'b0001);
        idle(); BType = 2'b01; rb_val = 8'h40; #1;
        check("beq_taken", 32'(branch_taken), 32'd1);
        check("beq_target", 32'(branch_target), 32'h40);
        cycle();
        idle(); BType = 2'b10; rb_val = 8'h40; #1;
        check("bc_taken", 32'(branch_taken), 32'd0);
        cycle();

        // Forwarding from EX/MEM combined with an immediate operand.
        idle(); ALU_src = 1; imm = 8'h10; cycle();
        idle(); ALU_op = 4'd1; fwd_a_sel = 2'b01; ALU_src = 1; imm = 8'h22; cycle();
        check("fwd_add", 32'(exmem_alu_result), 32'h32);
        idle(); ALU_op = 4'd3; ra_val = 8'h30; fwd_b_sel = 2'b10; wb_data = 8'h0F;
        UpdateFlags = 1; cycle();
        check("fwd_and", 32'(exmem_alu_result), 32'h00);
        check("fwd_and_z", 32'(ccr[0]), 32'd1);

        // Three stalled cycles with changing inputs: nothing may move.
        held = exmem_alu_result;
        for (int i = 0; i < 3; i++) begin
            alu(4'(i + 1), 8'(8'h11 * (i + 1)), 8'h9A, 1); stall = 1; RegWrite = 1;
            cycle();
            check("stall_hold", 32'(exmem_alu_result), 32'(held));
        end
        alu(4'd1, 8'h01, 8'h02, 1); cycle();
        check("stall_release", 32'(exmem_alu_result), 32'h03);

        // Shadow: build ccr=0101, save it, disturb it, then restore while a
        // flag write is requested in the same cycle.
        alu(4'd2, 8'h00, 8'h00, 1); cycle();
        alu(4'd11, 8'h00, 8'h00, 1); cycle();
        check("pre_save_ccr", 32'(ccr), 32'b0101);
        idle(); ccr_save = 1; cycle();
        alu(4'd1, 8'h80, 8'h80, 1); cycle();
        check("disturb_ccr", 32'(ccr), 32'b1101);
        alu(4'd1, 8'h7F, 8'h01, 1); ccr_restore = 1; cycle();
`ifdef EX_CCR_SHADOW_EN
        check("restore_ccr", 32'(ccr), 32'b0101);
`else
        check("restore_ccr", 32'(ccr), 32'b1010);
`endif

        // Random traffic checked against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0); stall = ($urandom_range(0, 7) == 0);
            BType = 2'($urandom); MemToReg = 2'($urandom); RegDistidx = 2'($urandom);
            RegWrite = 1'($urandom); MemWrite = 1'($urandom); MemRead = 1'($urandom);
            UpdateFlags = 1'($urandom); ALU_src = 1'($urandom); IO_Write = 1'($urandom);
            ALU_op = 4'($urandom); ra_val = 8'($urandom); rb_val = 8'($urandom);
            imm = 8'($urandom); pc_plus1 = 8'($urandom); ra = 2'($urandom); rb = 2'($urandom);
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom); wb_data = 8'($urandom);
            ccr_save = ($urandom_range(0, 5) == 0); ccr_restore = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
